// File: rtl/sram_access_unit_if.sv
// Request/response channel between the CPU memory stage and sram_access_unit.
// The master issues byte-addressed loads/stores; the slave returns one response each.
interface sram_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/sram_access_unit.sv
// Byte-addressed load/store front end for a 32-bit word SRAM with 1-cycle read latency.
// Misaligned accesses that straddle a word are split into two SRAM accesses.
module sram_access_unit #(
  parameter  int DEPTH    = 1024,
  localparam int LOGDEPTH = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  sram_access_unit_if.slave   req_if,
  output logic                sram_read_req,
  output logic [LOGDEPTH-1:0] sram_read_addr,
  input  logic [31:0]         sram_read_data,
  output logic                sram_write_req,
  output logic [LOGDEPTH-1:0] sram_write_addr,
  output logic [3:0]          sram_write_byte_en,
  output logic [31:0]         sram_write_data
);

  typedef enum logic [2:0] {IDLE, ACC1, ACC2, LDRESP, ERR} state_t;

  typedef struct packed {
    logic                write;
    logic [1:0]          size;
    logic                uns;
    logic [1:0]          off;
    logic [LOGDEPTH-1:0] word;
    logic [31:0]         wdata;
    logic                split;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] lo_q, lo_d;

  // Decode of the incoming request
  logic [1:0]          off_in;
  logic [2:0]          n_in;
  logic                split_in;
  logic [LOGDEPTH-1:0] word_in;
  logic                err_in;

  assign off_in   = req_if.req_addr[1:0];
  assign n_in     = (req_if.req_size == 2'd0) ? 3'd1 : (req_if.req_size == 2'd1) ? 3'd2 : 3'd4;
  assign split_in = ({1'b0, off_in} + n_in) > 3'd4;
  assign word_in  = req_if.req_addr[LOGDEPTH+1:2];
  // A split access into the last word would wrap to word 0, so it is rejected.
  assign err_in   = (req_if.req_size == 2'd3)
                 || ({1'b0, req_if.req_addr} >= 33'(4 * DEPTH))
                 || (split_in && (word_in == LOGDEPTH'(DEPTH - 1)));

  // Store lane placement over the two-word window starting at req_q.word
  logic [7:0]          base_mask;
  logic [7:0]          lane_mask;
  logic [63:0]         lane_data;
  logic [LOGDEPTH-1:0] word_next;

  assign base_mask = (req_q.size == 2'd0) ? 8'h01 : (req_q.size == 2'd1) ? 8'h03 : 8'h0F;
  assign lane_mask = base_mask << req_q.off;
  assign lane_data = {32'b0, req_q.wdata} << {req_q.off, 3'b000};
  assign word_next = req_q.word + LOGDEPTH'(1);

  // Load merge: hi word only exists for split loads, lo word was captured in ACC2
  logic [31:0] merged;
  logic [31:0] load_ext;

  assign merged = 32'((req_q.split ? {sram_read_data, lo_q} : {32'b0, sram_read_data})
                      >> {req_q.off, 3'b000});

  always_comb begin
    load_ext = merged;
    case (req_q.size)
      2'd0:    load_ext = req_q.uns ? {24'b0, merged[7:0]}  : {{24{merged[7]}}, merged[7:0]};
      2'd1:    load_ext = req_q.uns ? {16'b0, merged[15:0]} : {{16{merged[15]}}, merged[15:0]};
      default: load_ext = merged;
    endcase
  end

  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  always_comb begin
    state_d            = state_q;
    req_d              = req_q;
    lo_d               = lo_q;
    req_ready          = 1'b0;
    resp_valid         = 1'b0;
    resp_rdata         = 32'b0;
    resp_error         = 1'b0;
    sram_read_req      = 1'b0;
    sram_read_addr     = req_q.word;
    sram_write_req     = 1'b0;
    sram_write_addr    = req_q.word;
    sram_write_byte_en = 4'b0;
    sram_write_data    = 32'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_if.req_valid) begin
          req_d = '{write: req_if.req_write, size: req_if.req_size, uns: req_if.req_unsigned,
                    off: off_in, word: word_in, wdata: req_if.req_wdata, split: split_in};
          state_d = err_in ? ERR : ACC1;
        end
      end
      ACC1: begin
        if (req_q.write) begin
          sram_write_req     = 1'b1;
          sram_write_byte_en = lane_mask[3:0];
          sram_write_data    = lane_data[31:0];
          resp_valid         = !req_q.split;
        end else begin
          sram_read_req = 1'b1;
        end
        state_d = req_q.split ? ACC2 : (req_q.write ? IDLE : LDRESP);
      end
      ACC2: begin
        if (req_q.write) begin
          sram_write_req     = 1'b1;
          sram_write_addr    = word_next;
          sram_write_byte_en = lane_mask[7:4];
          sram_write_data    = lane_data[63:32];
          resp_valid         = 1'b1;
        end else begin
          sram_read_req  = 1'b1;
          sram_read_addr = word_next;
          lo_d           = sram_read_data;
        end
        state_d = req_q.write ? IDLE : LDRESP;
      end
      LDRESP: begin
        resp_valid = 1'b1;
        resp_rdata = load_ext;
        state_d    = IDLE;
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_error = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset abandons any in-flight access within the same cycle.
    if (reset) begin
      sram_read_req  = 1'b0;
      sram_write_req = 1'b0;
      resp_valid     = 1'b0;
      resp_rdata     = 32'b0;
      resp_error     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      lo_q    <= 32'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      lo_q    <= lo_d;
    end
  end

  assign req_if.req_ready  = req_ready;
  assign req_if.resp_valid = resp_valid;
  assign req_if.resp_rdata = resp_rdata;
  assign req_if.resp_error = resp_error;

endmodule

// File: tb/tb_sram_access_unit.sv
// Self-checking bench for sram_access_unit: directed scenarios plus randomized traffic
// checked against a byte-array memory model.
module tb_sram_access_unit;
  localparam int DEPTH  = 1024;
  localparam int NBYTES = 4 * DEPTH;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_access_unit_if bus();

  logic        sram_read_req;
  logic [9:0]  sram_read_addr;
  logic [31:0] sram_read_data;
  logic        sram_write_req;
  logic [9:0]  sram_write_addr;
  logic [3:0]  sram_write_byte_en;
  logic [31:0] sram_write_data;

  sram_access_unit #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .req_if             (bus),
    .sram_read_req      (sram_read_req),
    .sram_read_addr     (sram_read_addr),
    .sram_read_data     (sram_read_data),
    .sram_write_req     (sram_write_req),
    .sram_write_addr    (sram_write_addr),
    .sram_write_byte_en (sram_write_byte_en),
    .sram_write_data    (sram_write_data)
  );

  // Attached SRAM: registered read, byte-enabled write
  logic [31:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (sram_write_req)
      for (int b = 0; b < 4; b++)
        if (sram_write_byte_en[b]) sram_mem[sram_write_addr][8*b +: 8] <= sram_write_data[8*b +: 8];
    if (sram_read_req) sram_read_data <= sram_mem[sram_read_addr];
  end

  // Reference: plain little-endian byte memory
  logic [7:0] ref_mem [NBYTES];

  int total = 0;
  int bad   = 0;
  int txn_id = 0;

  logic [9:0]  wr_addr_log [2];
  logic [3:0]  wr_be_log   [2];
  logic [31:0] wr_data_log [2];
  int          wr_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input int n, input logic uns);
    logic [31:0] v;
    v = 32'b0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr + 32'(i)]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] got_rdata);
    int n, exp_lat, exp_nsram, lat, nsram, nresp, stray;
    logic err, split, got_err;
    logic [31:0] exp_rdata;
    n         = size_bytes(sz);
    err       = (sz == 2'd3) || (({32'b0, addr} + 64'(n)) > 64'(NBYTES));
    split     = (int'(addr & 32'h3) + n) > 4;
    exp_lat   = err ? 1 : (wr ? (split ? 2 : 1) : (split ? 3 : 2));
    exp_nsram = err ? 0 : (split ? 2 : 1);
    exp_rdata = (err || wr) ? 32'b0 : ref_load(addr, n, uns);

    @(negedge clk);
    check_eq("ready_idle", bus.req_ready, 1'b1);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    nresp = 0; lat = 0; nsram = 0; stray = 0; wr_cnt = 0;
    got_rdata = 32'b0; got_err = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (bus.resp_valid) begin
        nresp++;
        if (nresp == 1) begin
          lat = k; got_rdata = bus.resp_rdata; got_err = bus.resp_error;
        end
      end else if (bus.resp_rdata != 32'b0 || bus.resp_error) begin
        stray++;
      end
      if (sram_read_req || sram_write_req) nsram++;
      if (sram_read_req && sram_write_req) stray++;
      if (sram_write_req && wr_cnt < 2) begin
        wr_addr_log[wr_cnt] = sram_write_addr;
        wr_be_log[wr_cnt]   = sram_write_byte_en;
        wr_data_log[wr_cnt] = sram_write_data;
        wr_cnt++;
      end
      if (k < 6) @(negedge clk);
    end
    check_eq("resp_count", nresp, 1);
    check_eq("resp_latency", lat, exp_lat);
    check_eq("resp_rdata", got_rdata, exp_rdata);
    check_eq("resp_error", got_err, err);
    check_eq("sram_accesses", nsram, exp_nsram);
    check_eq("idle_outputs", stray, 0);
    if (wr && !err)
      for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wd[8*i +: 8];
    $display("txn %0d wr=%0d sz=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             txn_id, wr, sz, uns, addr, wd, got_rdata, got_err, lat);
    txn_id++;
  endtask

  initial begin
    logic [31:0] rd, w, addr;
    logic [1:0]  sz;
    int r, s, nbad;
    int idx, nacc, nr, last_acc;
    logic acc_prev;
    logic [31:0] b2b_addr [4];
    logic [1:0]  b2b_size [4];
    logic [31:0] b2b_exp  [4];

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'b0; bus.req_wdata = 32'b0;
    for (int j = 0; j < DEPTH; j++) begin
      w = $urandom;
      sram_mem[j] <= w;
      for (int b = 0; b < 4; b++) ref_mem[4*j + b] = w[8*b +: 8];
    end

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_resp_valid", bus.resp_valid, 1'b0);
    check_eq("rst_resp_rdata", bus.resp_rdata, 32'b0);
    check_eq("rst_resp_error", bus.resp_error, 1'b0);
    check_eq("rst_sram_req", {sram_read_req, sram_write_req}, 2'b00);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", bus.req_ready, 1'b1);

    // Aligned word store then load
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd);
    check_eq("st_w_addr", wr_addr_log[0], 10'd4);
    check_eq("st_w_be", wr_be_log[0], 4'b1111);
    check_eq("st_w_data", wr_data_log[0], 32'hDEADBEEF);
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd);
    check_eq("ld_w", rd, 32'hDEADBEEF);

    // Sub-word loads with extension
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF1234, rd);
    run_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd);
    check_eq("ld_b_signed", rd, 32'hFFFFFF80);
    run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd);
    check_eq("ld_b_unsigned", rd, 32'h00000080);
    run_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd);
    check_eq("ld_h_signed", rd, 32'hFFFF80FF);

    // Split word store and load
    run_req(1'b1, 2'd2, 1'b0, 32'h0E, 32'h11223344, rd);
    check_eq("split_wr_cnt", wr_cnt, 2);
    check_eq("split_a0", wr_addr_log[0], 10'd3);
    check_eq("split_be0", wr_be_log[0], 4'b1100);
    check_eq("split_d0", wr_data_log[0], 32'h33440000);
    check_eq("split_a1", wr_addr_log[1], 10'd4);
    check_eq("split_be1", wr_be_log[1], 4'b0011);
    check_eq("split_d1", wr_data_log[1], 32'h00001122);
    run_req(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, rd);
    check_eq("split_ld", rd, 32'h11223344);

    // Rejected requests
    run_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, rd);
    run_req(1'b0, 2'd1, 1'b0, 32'hFFF, 32'h0, rd);
    run_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, rd);

    // Reset during ACC1 of a split store
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd2;
    bus.req_addr = 32'h0E; bus.req_wdata = 32'hAABBCCDD;
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("rst_mid_wr", sram_write_req, 1'b0);
    check_eq("rst_mid_resp", bus.resp_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_after_wr", sram_write_req, 1'b0);
    check_eq("rst_after_resp", bus.resp_valid, 1'b0);
    @(negedge clk);
    check_eq("rst_after_ready", bus.req_ready, 1'b1);
    check_eq("rst_after_wr2", sram_write_req, 1'b0);
    run_req(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, rd);
    check_eq("rst_no_write", rd, 32'h11223344);

    // Back-to-back loads with req_valid held
    b2b_addr[0] = 32'h10; b2b_addr[1] = 32'h20; b2b_addr[2] = 32'h0C; b2b_addr[3] = 32'h31;
    b2b_size[0] = 2'd2;   b2b_size[1] = 2'd1;   b2b_size[2] = 2'd2;   b2b_size[3] = 2'd0;
    for (int i = 0; i < 4; i++) b2b_exp[i] = ref_load(b2b_addr[i], size_bytes(b2b_size[i]), 1'b0);
    idx = 0; nacc = 0; nr = 0; last_acc = 0; acc_prev = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_unsigned = 1'b0;
    bus.req_addr = b2b_addr[0]; bus.req_size = b2b_size[0];
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      if (acc_prev) begin
        idx++;
        if (idx < 4) begin
          bus.req_addr = b2b_addr[idx]; bus.req_size = b2b_size[idx];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
      if (bus.resp_valid) begin
        if (nr < 4) check_eq("b2b_rdata", bus.resp_rdata, b2b_exp[nr]);
        nr++;
      end
      acc_prev = bus.req_valid && bus.req_ready;
      if (acc_prev) begin
        if (nacc > 0) check_eq("b2b_gap", c - last_acc, 3);
        last_acc = c;
        nacc++;
      end
    end
    check_eq("b2b_accepts", nacc, 4);
    check_eq("b2b_resps", nr, 4);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      addr = $urandom_range(0, 63);
      else if (r < 85) addr = 32'(NBYTES - 16) + $urandom_range(0, 15);
      else if (r < 93) addr = $urandom;
      else             addr = $urandom_range(0, NBYTES - 1);
      s  = $urandom_range(0, 9);
      sz = (s < 9) ? 2'(s % 3) : 2'd3;
      run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom, rd);
    end

    // Whole-memory consistency
    @(negedge clk);
    nbad = 0;
    for (int j = 0; j < DEPTH; j++)
      for (int b = 0; b < 4; b++)
        if (sram_mem[j][8*b +: 8] !== ref_mem[4*j + b]) nbad++;
    check_eq("mem_final", nbad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_access_unit.md
Name: sram_access_unit

Overview:
- Initiator-side front end for the single-port-pair word SRAM (1-cycle registered read, byte-enabled write).
- Accepts byte-addressed RISC-V-style load/store requests (byte/half/word, signed/unsigned) over a valid/ready handshake.
- Splits accesses that cross a word boundary into two SRAM accesses and merges/extends load data.
- Returns one response per request; sits between the CPU memory stage and the SRAM.

Parameters:
- DEPTH, 1024, number of 32-bit words in the attached SRAM.
- LOGDEPTH, $clog2(DEPTH), local; SRAM word-address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal.
- req_unsigned  in  1  loads: zero-extend if 1, sign-extend if 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  request rejected, no SRAM access made.
- sram_read_req  out  1  to SRAM read_req.
- sram_read_addr  out  LOGDEPTH  word address.
- sram_read_data  in  32  SRAM data, valid the cycle after sram_read_req.
- sram_write_req  out  1  to SRAM write_req.
- sram_write_addr  out  LOGDEPTH  word address.
- sram_write_byte_en  out  4  byte lanes.
- sram_write_data  out  32  lane-aligned data.

Behaviour:
- Reset: state IDLE; resp_valid=0, resp_rdata=0, resp_error=0. sram_read_req and sram_write_req are forced 0 in any cycle with reset high.
- Reset mid-operation: request abandoned, no response. A write issued in an earlier cycle stays committed. req_ready=1 the cycle after reset deasserts.
- Accept: req_valid && req_ready at edge T. The request is registered.
- Decode: W = req_addr[LOGDEPTH+1:2]; off = req_addr[1:0]; n = 1, 2 or 4 bytes; split = (off + n > 4).
- Error (size==3, req_addr >= 4*DEPTH, or split with W+1 == DEPTH; no wrap-around):
  - State ERR at T+1; resp_valid=1, resp_error=1, rdata 0.
  - No SRAM request is issued.
- States: IDLE, ACC1, ACC2, LDRESP, ERR. Every non-IDLE state lasts one cycle.
  - Response states return to IDLE.
  - ACC1 goes to ACC2 if split, else to LDRESP (load) or IDLE (store).
  - ACC2 goes to LDRESP (load) or IDLE (store).
- Store lanes:
  - D = zero-extended {32'b0, wdata} << 8*off (64 bits); M = ((1<<n)-1) << off (8 bits).
  - Word W gets D[31:0] / M[3:0]; word W+1 gets D[63:32] / M[7:4].
- Store timing:
  - ACC1 (T+1): write W.
  - Unsplit: resp_valid at T+1.
  - Split: ACC2 (T+2) writes W+1; resp_valid at T+2.
- Load timing:
  - ACC1 (T+1): read W.
  - Unsplit: LDRESP at T+2.
  - Split: ACC2 (T+2) captures word W into lo and reads W+1; LDRESP at T+3.
- Load merge (in LDRESP):
  - hi = current sram_read_data when split, else 0; lo is the captured word when split, else the current sram_read_data.
  - X = {hi,lo} >> 8*off; take low n bytes; sign-extend from bit 8n-1 unless req_unsigned.
  - resp_error=0.
- Outputs:
  - resp_valid is high for exactly one cycle per accepted request.
  - resp_rdata and resp_error hold their value only during resp_valid and are 0 otherwise.
  - The SRAM request outputs are high only in ACC1/ACC2, and only one of read or write is high.
- req_valid during busy states is ignored; the requester must hold it.

Test Plan:
1. Reset; store word 0x10, data 0xDEADBEEF accepted at T -> T+1: write_req, addr 4, be 1111, resp_valid. Then load word 0x10 -> resp_rdata 0xDEADBEEF at T+2.
2. Word 4 preloaded 0x80FF1234:
   - Signed byte load 0x13 -> 0xFFFFFF80.
   - Unsigned byte load 0x13 -> 0x00000080.
   - Signed half load 0x12 -> 0xFFFF80FF.
3. Split store word 0x0E, data 0x11223344:
   - T+1: addr 3, be 1100, data 0x33440000.
   - T+2: addr 4, be 0011, data 0x00001122; resp at T+2.
   - Load word 0x0E -> 0x11223344 at T+3.
4. Errors, each responding at T+1 with resp_error=1 and no SRAM request:
   - Load word 0x1000.
   - Half at 0xFFF (split into W+1=1024).
   - size=3 at 0x0.
5. Reset asserted during ACC1 of the split store in scenario 3 -> no W+1 write, no resp_valid; req_ready=1 the cycle after reset falls.
6. Hold req_valid continuously for back-to-back unsplit loads -> accepts every 3 cycles, req_ready low in ACC1/LDRESP, responses in order.
